// File: rtl/lcd_timing_pkg.sv
// Shared timing constants and helpers for the LCD raster generator.
package lcd_timing_pkg;
    localparam int ADDR_W    = 11;
    localparam int MAX_TOTAL = 1 << ADDR_W;

    localparam int DEF_H_SYNC   = 1;
    localparam int DEF_H_BACK   = 46;
    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FRONT  = 210;
    localparam int DEF_V_SYNC   = 1;
    localparam int DEF_V_BACK   = 23;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 22;

    typedef logic [ADDR_W-1:0] addr_t;

    function automatic int total4(input int sync_w, input int back, input int active,
                                  input int front);
        return sync_w + back + active + front;
    endfunction
endpackage

// File: rtl/lcd_sync_module_if.sv
// Timing outputs from the raster generator towards the panel and the pixel fetch logic.
interface lcd_sync_module_if;
    import lcd_timing_pkg::*;
    logic  hsync_sig;
    logic  vsync_sig;
    logic  ready_sig;
    addr_t column_addr_sig;
    addr_t row_addr_sig;
    logic  frame_start_sig;

    modport master (output hsync_sig, vsync_sig, ready_sig, column_addr_sig, row_addr_sig,
                    frame_start_sig);
    modport slave  (input  hsync_sig, vsync_sig, ready_sig, column_addr_sig, row_addr_sig,
                    frame_start_sig);
endinterface

// File: rtl/lcd_timing_counter.sv
// Wrapping counter 0..LIMIT-1 with enable; wrap is high on the enabled cycle that returns to 0.
module lcd_timing_counter
    import lcd_timing_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    output addr_t cnt,
    output logic  wrap
);
    addr_t cnt_q, cnt_d;

    assign wrap = en && (cnt_q == addr_t'(LIMIT - 1));
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en) cnt_d = wrap ? '0 : cnt_q + addr_t'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/lcd_sync_module.sv
// Raster timing generator: hsync/vsync, data-enable and pixel addresses for an RGB panel.
// Define LCD_ADDR_LEAD_EN to make the addresses lead ready_sig by one clock.
module lcd_sync_module
    import lcd_timing_pkg::*;
#(
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BACK   = DEF_H_BACK,
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FRONT  = DEF_H_FRONT,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BACK   = DEF_V_BACK,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FRONT  = DEF_V_FRONT,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    lcd_sync_module_if.master   lcd
);
    localparam int H_TOTAL = total4(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
    localparam int V_TOTAL = total4(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);

    localparam addr_t H_SYNC_E = addr_t'(H_SYNC);
    localparam addr_t H_ACT_S  = addr_t'(H_SYNC + H_BACK);
    localparam addr_t H_ACT_E  = addr_t'(H_SYNC + H_BACK + H_ACTIVE);
    localparam addr_t V_SYNC_E = addr_t'(V_SYNC);
    localparam addr_t V_ACT_S  = addr_t'(V_SYNC + V_BACK);
    localparam addr_t V_ACT_E  = addr_t'(V_SYNC + V_BACK + V_ACTIVE);

    generate
        if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_size_err
            $error("lcd_sync_module: H_TOTAL/V_TOTAL exceed 11-bit counter range");
        end
    endgenerate

    addr_t h_cnt, v_cnt;
    logic  h_wrap, v_wrap;

    lcd_timing_counter #(.LIMIT(H_TOTAL)) u_h_cnt (
        .clk(clk), .rst(rst), .en(1'b1), .cnt(h_cnt), .wrap(h_wrap));

    lcd_timing_counter #(.LIMIT(V_TOTAL)) u_v_cnt (
        .clk(clk), .rst(rst), .en(h_wrap), .cnt(v_cnt), .wrap(v_wrap));

    logic  h_act, v_act;
    addr_t h_src, v_src;
    logic  h_src_act, v_src_act;

    assign h_act = (h_cnt >= H_ACT_S) && (h_cnt < H_ACT_E);
    assign v_act = (v_cnt >= V_ACT_S) && (v_cnt < V_ACT_E);

`ifdef LCD_ADDR_LEAD_EN
    // Addresses come from the next raster position so the consumer's fetch lands on ready.
    assign h_src = h_wrap ? '0 : h_cnt + addr_t'(1);
    assign v_src = h_wrap ? (v_wrap ? '0 : v_cnt + addr_t'(1)) : v_cnt;
`else
    assign h_src = h_cnt;
    assign v_src = v_cnt;
`endif
    assign h_src_act = (h_src >= H_ACT_S) && (h_src < H_ACT_E);
    assign v_src_act = (v_src >= V_ACT_S) && (v_src < V_ACT_E);

    logic  hsync_q, hsync_d, vsync_q, vsync_d, ready_q, ready_d, frame_start_q, frame_start_d;
    addr_t col_q, col_d, row_q, row_d;

    always_comb begin
        hsync_d       = (h_cnt < H_SYNC_E) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = (v_cnt < V_SYNC_E) ? SYNC_POL : ~SYNC_POL;
        ready_d       = h_act && v_act;
        frame_start_d = (h_cnt == H_ACT_S) && (v_cnt == V_ACT_S);
        col_d         = (h_src_act && v_src_act) ? h_src - H_ACT_S : '0;
        row_d         = v_src_act ? v_src - V_ACT_S : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            ready_q       <= 1'b0;
            frame_start_q <= 1'b0;
            col_q         <= '0;
            row_q         <= '0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            ready_q       <= ready_d;
            frame_start_q <= frame_start_d;
            col_q         <= col_d;
            row_q         <= row_d;
        end
    end

    assign lcd.hsync_sig       = hsync_q;
    assign lcd.vsync_sig       = vsync_q;
    assign lcd.ready_sig       = ready_q;
    assign lcd.frame_start_sig = frame_start_q;
    assign lcd.column_addr_sig = col_q;
    assign lcd.row_addr_sig    = row_q;
endmodule

// File: tb/tb_lcd_sync_module.sv
// Bench for lcd_sync_module on a shrunken raster; expected outputs come from raster arithmetic.
module tb_lcd_sync_module;
    localparam int HS = 2, HB = 3, HA = 8, HF = 4;
    localparam int VS = 1, VB = 2, VA = 4, VF = 3;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FT = HT * VT;
    localparam int HAS = HS + HB;
    localparam int VAS = VS + VB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_sync_module_if lcd();

    lcd_sync_module #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .lcd(lcd)
    );

    int total = 0;
    int bad   = 0;
    int pos   = 0;      // raster position the next output edge will reflect
    int ready_cnt = 0;
    int fs_cnt    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic bit in_h(input int h);
        return h >= HAS && h < HAS + HA;
    endfunction
    function automatic bit in_v(input int v);
        return v >= VAS && v < VAS + VA;
    endfunction

    // One clock: compare every output against the raster model, then advance the model.
    task automatic tick();
        int h, v, ah, av, p2;
        logic e_hs, e_vs, e_rdy, e_fs;
        int e_col, e_row;
        @(posedge clk);
        #1;
        if (rst) begin
            e_hs = 1'b1; e_vs = 1'b1; e_rdy = 1'b0; e_fs = 1'b0; e_col = 0; e_row = 0;
            pos = 0;
        end else begin
            h = pos % HT;
            v = pos / HT;
            e_hs  = !(h < HS);
            e_vs  = !(v < VS);
            e_rdy = in_h(h) && in_v(v);
            e_fs  = (h == HAS) && (v == VAS);
`ifdef LCD_ADDR_LEAD_EN
            p2 = (pos + 1) % FT;
`else
            p2 = pos;
`endif
            ah = p2 % HT;
            av = p2 / HT;
            e_col = (in_h(ah) && in_v(av)) ? ah - HAS : 0;
            e_row = in_v(av) ? av - VAS : 0;
            pos = (pos + 1) % FT;
        end
        chk("hsync", 32'(lcd.hsync_sig), 32'(e_hs));
        chk("vsync", 32'(lcd.vsync_sig), 32'(e_vs));
        chk("ready", 32'(lcd.ready_sig), 32'(e_rdy));
        chk("frame_start", 32'(lcd.frame_start_sig), 32'(e_fs));
        chk("column", 32'(lcd.column_addr_sig), 32'(e_col));
        chk("row", 32'(lcd.row_addr_sig), 32'(e_row));
        if (lcd.ready_sig === 1'b1) ready_cnt++;
        if (lcd.frame_start_sig === 1'b1) fs_cnt++;
    endtask

    initial begin
        int last_fs, n, k, hs_low;
        bit seen;

        // Reset held 5 cycles
        rst = 1'b1;
        repeat (5) tick();

        // First cycle after release shows h_cnt=0: hsync asserted
        rst = 1'b0;
        tick();
        chk("hsync_first_after_rst", 32'(lcd.hsync_sig), 32'd0);

        // One line: hsync low exactly HS cycles
        hs_low = (lcd.hsync_sig === 1'b0) ? 1 : 0;
        for (int i = 1; i < HT; i++) begin
            tick();
            if (lcd.hsync_sig === 1'b0) hs_low++;
        end
        chk("hsync_width", 32'(hs_low), 32'(HS));

        // Two full frames: active pixel count, frame_start count and period
        ready_cnt = 0; fs_cnt = 0; last_fs = -1; n = 0;
        for (int i = 0; i < 2 * FT; i++) begin
            tick();
            n++;
            if (lcd.frame_start_sig === 1'b1) begin
                if (last_fs >= 0) chk("frame_period", 32'(n - last_fs), 32'(FT));
                last_fs = n;
            end
        end
        chk("ready_cycles_2frames", 32'(ready_cnt), 32'(2 * HA * VA));
        chk("frame_starts_2frames", 32'(fs_cnt), 32'd2);

        // Mid-frame reset at row 2, column 3 of the active area
        k = 0;
        while (pos != (VAS + 2) * HT + HAS + 3 && k < 2 * FT) begin tick(); k++; end
        chk("reach_mid_frame", 32'(pos), 32'((VAS + 2) * HT + HAS + 3));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();                             // first output cycle from counter 0
        n = 0; seen = 1'b0;
        while (!seen && n < 2 * FT) begin
            tick();
            n++;
            if (lcd.frame_start_sig === 1'b1) seen = 1'b1;
        end
        chk("frame_start_after_rst", 32'(n), 32'(VAS * HT + HAS));

        // Random free-run bursts interleaved with random-length resets
        for (int r = 0; r < 20; r++) begin
            n = $urandom_range(1, 2 * FT);
            for (int i = 0; i < n; i++) tick();
            rst = 1'b1;
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) tick();
            rst = 1'b0;
        end
        repeat (FT + 5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
